bit_matrix_framer: RTL and testbench

Renders BCD clock digits into the packed per-LED colour frame consumed by the ws2812 driver. Sits between the time-digit counters (upstream) and `ws2812` (downstream). On each `update` request it snapshots its inputs, computes one LED per cycle into a shadow buffer with brightness scaling, then commits the whole frame in one cycle, so the driver never sees a half-built frame.

---
 rtl/bit_matrix_framer.sv | 143 ++++++++++++++
 tb/tb_bit_matrix_framer.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/bit_matrix_framer.sv
// bit_matrix_framer: renders BCD digit bits into a packed per-LED colour frame.
// Inputs are snapshotted on a render request, one LED is scaled and written to a
// shadow buffer per cycle, and the finished frame is committed in a single cycle.
module bit_matrix_framer #(
    parameter int unsigned NUM_LEDS = 16
) (
    input  logic                    hwclk,
    input  logic                    reset,
    input  logic                    update,
    input  logic [NUM_LEDS-1:0]     digits,
    input  logic [23:0]             on_colour,
    input  logic [23:0]             off_colour,
    input  logic [7:0]              brightness,
    output logic [24*NUM_LEDS-1:0]  packed_rgb_data,
    output logic                    busy,
    output logic                    frame_valid
);

    localparam int unsigned IdxW = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;
    localparam logic [IdxW-1:0] LastIdx = IdxW'(NUM_LEDS - 1);

    typedef enum logic [1:0] {StIdle, StRender, StCommit} state_e;

    state_e                  state_q, state_d;
    logic [IdxW-1:0]         idx_q, idx_d;
    logic                    pending_q, pending_d;
    logic                    snap_en, shadow_we, commit;

    logic [NUM_LEDS-1:0]     digits_q;
    logic [23:0]             on_q, off_q;
    logic [7:0]              bright_q;
    logic [24*NUM_LEDS-1:0]  shadow_q;
    logic [24*NUM_LEDS-1:0]  frame_q;
    logic                    frame_valid_q;

    logic [23:0]             pixel_raw;
    logic [23:0]             pixel_scaled;

    // (ch * (brightness + 1)) >> 8 in 17 bits; 255 is a pass-through, 0 blanks.
    function automatic logic [7:0] scale(input logic [7:0] ch, input logic [7:0] br);
        logic [16:0] prod;
        prod = {9'd0, ch} * ({9'd0, br} + 17'd1);
        return 8'(prod >> 8);
    endfunction

    // Colour of the LED currently being rendered, each byte scaled independently.
    always_comb begin
        pixel_raw    = digits_q[idx_q] ? on_q : off_q;
        pixel_scaled = {scale(pixel_raw[23:16], bright_q),
                        scale(pixel_raw[15:8],  bright_q),
                        scale(pixel_raw[7:0],   bright_q)};
    end

    // Next-state and control decode.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        pending_d = pending_q;
        snap_en   = 1'b0;
        shadow_we = 1'b0;
        commit    = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (update) begin
                    snap_en = 1'b1;
                    idx_d   = '0;
                    state_d = StRender;
                end
            end
            StRender: begin
                shadow_we = 1'b1;
                idx_d     = idx_q + 1'b1;
                // Any number of requests mid-render collapse into one follow-up.
                if (update) begin
                    pending_d = 1'b1;
                end
                if (idx_q == LastIdx) begin
                    idx_d   = '0;
                    state_d = StCommit;
                end
            end
            StCommit: begin
                commit = 1'b1;
                if (pending_q || update) begin
                    snap_en   = 1'b1;
                    pending_d = 1'b0;
                    idx_d     = '0;
                    state_d   = StRender;
                end else begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // FSM state, LED index and pending-request flag.
    always_ff @(posedge hwclk) begin
        if (reset) begin
            state_q   <= StIdle;
            idx_q     <= '0;
            pending_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            pending_q <= pending_d;
        end
    end

    // Snapshot, shadow buffer and committed frame.
    always_ff @(posedge hwclk) begin
        if (reset) begin
            digits_q      <= '0;
            on_q          <= '0;
            off_q         <= '0;
            bright_q      <= '0;
            shadow_q      <= '0;
            frame_q       <= '0;
            frame_valid_q <= 1'b0;
        end else begin
            if (snap_en) begin
                digits_q <= digits;
                on_q     <= on_colour;
                off_q    <= off_colour;
                bright_q <= brightness;
            end
            if (shadow_we) begin
                shadow_q[24*idx_q +: 24] <= pixel_scaled;
            end
            if (commit) begin
                frame_q <= shadow_q;
            end
            frame_valid_q <= commit;
        end
    end

    assign packed_rgb_data = frame_q;
    assign frame_valid     = frame_valid_q;
    assign busy            = (state_q != StIdle);

endmodule

// File: tb/tb_bit_matrix_framer.sv
// Directed self-checking bench for bit_matrix_framer (16 LEDs).
module tb_bit_matrix_framer;

    localparam int N  = 16;
    localparam int FW = 24 * N;

    logic          hwclk = 1'b0;
    logic          reset;
    logic          update;
    logic [N-1:0]  digits;
    logic [23:0]   on_colour;
    logic [23:0]   off_colour;
    logic [7:0]    brightness;
    logic [FW-1:0] packed_rgb_data;
    logic          busy;
    logic          frame_valid;

    int vec_cnt = 0;
    int err_cnt = 0;

    bit_matrix_framer #(.NUM_LEDS(N)) dut (
        .hwclk           (hwclk),
        .reset           (reset),
        .update          (update),
        .digits          (digits),
        .on_colour       (on_colour),
        .off_colour      (off_colour),
        .brightness      (brightness),
        .packed_rgb_data (packed_rgb_data),
        .busy            (busy),
        .frame_valid     (frame_valid)
    );

    always #5 hwclk = ~hwclk;

    // Advance one edge and settle just after it.
    task automatic tick;
        @(posedge hwclk);
        #1;
    endtask

    // Frame with colour a on LEDs whose mask bit is set, colour b elsewhere.
    function automatic logic [FW-1:0] mk(input logic [N-1:0] mask, input logic [23:0] a,
                                         input logic [23:0] b);
        logic [FW-1:0] f;
        for (int i = 0; i < N; i++) f[24*i +: 24] = mask[i] ? a : b;
        return f;
    endfunction

    // Wait for a frame_valid pulse; n = edges waited, or -1 on timeout.
    task automatic wait_fv(input int max, output int n);
        bit seen;
        seen = 1'b0;
        n    = 0;
        while (!seen && n < max) begin
            tick;
            n++;
            seen = (frame_valid === 1'b1);
        end
        if (!seen) n = -1;
    endtask

    task automatic test_reset;
        int pulses;
        reset = 1'b1; update = 1'b0; digits = '0;
        on_colour = '0; off_colour = '0; brightness = '0;
        tick; tick;
        reset = 1'b0;
        tick;
        vec_cnt++;
        if (packed_rgb_data !== '0) begin
            err_cnt++; $display("FAIL reset_frame: got %h want 0", packed_rgb_data);
        end
        vec_cnt++;
        if (busy !== 1'b0 || frame_valid !== 1'b0) begin
            err_cnt++; $display("FAIL reset_flags: got busy=%b fv=%b want 0 0", busy, frame_valid);
        end
        pulses = 0;
        for (int i = 0; i < 50; i++) begin
            tick;
            if (frame_valid !== 1'b0 || busy !== 1'b0) pulses++;
        end
        vec_cnt++;
        if (pulses != 0 || packed_rgb_data !== '0) begin
            err_cnt++;
            $display("FAIL idle_quiet: got %0d active cycles frame %h want 0", pulses,
                     packed_rgb_data);
        end
    endtask

    task automatic test_basic;
        logic [FW-1:0] exp;
        exp = mk(16'h2359, 24'h101010, 24'h000000);
        digits = 16'h2359; on_colour = 24'h101010; off_colour = 24'h0; brightness = 8'd255;
        update = 1'b1;
        tick;
        update = 1'b0;
        vec_cnt++;
        if (busy !== 1'b1) begin
            err_cnt++; $display("FAIL basic_busy_start: got %b want 1", busy);
        end
        for (int i = 0; i < 16; i++) tick;
        vec_cnt++;
        if (frame_valid !== 1'b0 || packed_rgb_data !== '0 || busy !== 1'b1) begin
            err_cnt++;
            $display("FAIL basic_early: got fv=%b busy=%b frame %h want 0 1 0", frame_valid, busy,
                     packed_rgb_data);
        end
        tick;
        vec_cnt++;
        if (frame_valid !== 1'b1 || busy !== 1'b0) begin
            err_cnt++;
            $display("FAIL basic_latency17: got fv=%b busy=%b want 1 0", frame_valid, busy);
        end
        vec_cnt++;
        if (packed_rgb_data !== exp) begin
            err_cnt++; $display("FAIL basic_frame: got %h want %h", packed_rgb_data, exp);
        end
        tick;
        vec_cnt++;
        if (frame_valid !== 1'b0 || packed_rgb_data !== exp) begin
            err_cnt++;
            $display("FAIL basic_pulse_width: got fv=%b frame %h want 0 %h", frame_valid,
                     packed_rgb_data, exp);
        end
    endtask

    // Render one frame and check its latency and contents.
    task automatic render_check(input string name, input logic [FW-1:0] exp);
        int n;
        update = 1'b1;
        tick;
        update = 1'b0;
        wait_fv(40, n);
        vec_cnt++;
        if (n != 17) begin
            err_cnt++; $display("FAIL %s_latency: got %0d want 17", name, n);
        end
        vec_cnt++;
        if (packed_rgb_data !== exp) begin
            err_cnt++; $display("FAIL %s_frame: got %h want %h", name, packed_rgb_data, exp);
        end
        tick;
    endtask

    task automatic test_scale;
        // 0xFF,0x80,0x01 * 128 >> 8 = 7F,40,00 ; 0x02,0x04,0x06 -> 01,02,03
        digits = 16'h0001; on_colour = 24'hFF8001; off_colour = 24'h020406; brightness = 8'd127;
        render_check("scale127", mk(16'h0001, 24'h7F4000, 24'h010203));
        digits = 16'h8001; on_colour = 24'hAABBCC; off_colour = 24'h010203; brightness = 8'd255;
        render_check("order255", mk(16'h8001, 24'hAABBCC, 24'h010203));
        digits = 16'hFFFF; on_colour = 24'hFFFFFF; off_colour = 24'h123456; brightness = 8'd0;
        render_check("bright0", '0);
    endtask

    task automatic test_snapshot;
        int n;
        int extra;
        digits = 16'h1234; on_colour = 24'h00FF00; off_colour = 24'h0; brightness = 8'd255;
        update = 1'b1;
        tick;
        update = 1'b0;
        for (int i = 0; i < 5; i++) tick;
        digits = 16'hFFFF; on_colour = 24'hFF0000; off_colour = 24'h0000FF; brightness = 8'd1;
        wait_fv(40, n);
        vec_cnt++;
        if (n != 12) begin
            err_cnt++; $display("FAIL snap_latency: got %0d want 12", n);
        end
        vec_cnt++;
        if (packed_rgb_data !== mk(16'h1234, 24'h00FF00, 24'h0)) begin
            err_cnt++;
            $display("FAIL snap_frame: got %h want %h", packed_rgb_data,
                     mk(16'h1234, 24'h00FF00, 24'h0));
        end
        extra = 0;
        for (int i = 0; i < 40; i++) begin
            tick;
            if (frame_valid !== 1'b0 || busy !== 1'b0) extra++;
        end
        vec_cnt++;
        if (extra != 0) begin
            err_cnt++; $display("FAIL snap_single_frame: got %0d active cycles want 0", extra);
        end
    endtask

    task automatic test_back_to_back;
        int fv_at[$];
        int busy_drops;
        logic [FW-1:0] f1, f2;
        f1 = '0; f2 = '0;
        busy_drops = 0;
        digits = 16'h000F; on_colour = 24'h0000FF; off_colour = 24'h0; brightness = 8'd255;
        update = 1'b1;
        tick;
        for (int c = 1; c <= 60; c++) begin
            update = (c == 3 || c == 7 || c == 11);
            if (c == 12) begin
                digits = 16'hF000; on_colour = 24'hFF0000; off_colour = 24'h000100;
            end
            tick;
            if (frame_valid === 1'b1) begin
                fv_at.push_back(c);
                if (fv_at.size() == 1) f1 = packed_rgb_data;
                if (fv_at.size() == 2) f2 = packed_rgb_data;
            end
            if (c < 34 && busy !== 1'b1) busy_drops++;
        end
        update = 1'b0;
        vec_cnt++;
        if (fv_at.size() != 2) begin
            err_cnt++; $display("FAIL b2b_pulse_count: got %0d want 2", fv_at.size());
        end else begin
            vec_cnt++;
            if (fv_at[0] != 17 || fv_at[1] != 34) begin
                err_cnt++;
                $display("FAIL b2b_pulse_times: got %0d,%0d want 17,34", fv_at[0], fv_at[1]);
            end
        end
        vec_cnt++;
        if (busy_drops != 0 || busy !== 1'b0) begin
            err_cnt++;
            $display("FAIL b2b_busy: got %0d drops final busy=%b want 0 0", busy_drops, busy);
        end
        vec_cnt++;
        if (f1 !== mk(16'h000F, 24'h0000FF, 24'h0)) begin
            err_cnt++;
            $display("FAIL b2b_frame1: got %h want %h", f1, mk(16'h000F, 24'h0000FF, 24'h0));
        end
        vec_cnt++;
        if (f2 !== mk(16'hF000, 24'hFF0000, 24'h000100)) begin
            err_cnt++;
            $display("FAIL b2b_frame2: got %h want %h", f2, mk(16'hF000, 24'hFF0000, 24'h000100));
        end
    endtask

    task automatic test_reset_abort;
        int pulses;
        digits = 16'hFFFF; on_colour = 24'h112233; off_colour = 24'h0; brightness = 8'd255;
        update = 1'b1;
        tick;
        update = 1'b0;
        for (int i = 0; i < 8; i++) tick;
        reset = 1'b1;
        tick;
        reset = 1'b0;
        vec_cnt++;
        if (packed_rgb_data !== '0 || busy !== 1'b0 || frame_valid !== 1'b0) begin
            err_cnt++;
            $display("FAIL abort_outputs: got busy=%b fv=%b frame %h want 0 0 0", busy,
                     frame_valid, packed_rgb_data);
        end
        pulses = 0;
        for (int i = 0; i < 30; i++) begin
            tick;
            if (frame_valid !== 1'b0) pulses++;
        end
        vec_cnt++;
        if (pulses != 0 || packed_rgb_data !== '0) begin
            err_cnt++;
            $display("FAIL abort_no_frame: got %0d pulses frame %h want 0", pulses,
                     packed_rgb_data);
        end
        digits = 16'h0F0F; on_colour = 24'h112233; off_colour = 24'h0; brightness = 8'd255;
        render_check("after_abort", mk(16'h0F0F, 24'h112233, 24'h0));
    endtask

    initial begin
        test_reset;
        test_basic;
        test_scale;
        test_snapshot;
        test_back_to_back;
        test_reset_abort;
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
